// File: rtl/y86_fetch_sequencer_if.sv
// y86_fetch_sequencer_if: PC request, byte-memory and instruction-result bundle
// slave  : the fetch sequencer (takes PC / memory data, produces reads and decoded fields)
// master : the core / memory side driving PC, read data and instruction acceptance
interface y86_fetch_sequencer_if;
    logic [63:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_rd;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_rvalid;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        halt;
    logic        instr_invalid;
    logic        imem_error;

    modport master (
        output pc_in, pc_valid, imem_rdata, imem_rvalid, instr_ready,
        input  pc_ready, imem_rd, imem_addr, instr_valid, icode, ifun, ra, rb,
               valc, valp, halt, instr_invalid, imem_error
    );

    modport slave (
        input  pc_in, pc_valid, imem_rdata, imem_rvalid, instr_ready,
        output pc_ready, imem_rd, imem_addr, instr_valid, icode, ifun, ra, rb,
               valc, valp, halt, instr_invalid, imem_error
    );
endinterface

// File: rtl/y86_fetch_sequencer.sv
// y86_fetch_sequencer: byte-serial Y86-64 instruction fetch (PC in, 1..10 byte reads, decoded fields out)
// i_clk   : clock, rising edge
// i_rst_n : asynchronous active-low reset
// bus     : slave side of y86_fetch_sequencer_if (PC handshake, byte memory port, instruction handshake)
module y86_fetch_sequencer #(
    parameter int MEM_BYTES = 1024
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    y86_fetch_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic        r_pc_ready;
    logic [63:0] r_pc;
    logic [3:0]  r_idx;
    logic [3:0]  r_len;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic        r_halt;
    logic        r_invalid;
    logic        r_error;

    logic [63:0] w_addr;
    logic        w_addr_bad;
    logic        w_req_ok;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic        w_invalid;
    logic [3:0]  w_len;
    logic [3:0]  w_cur_len;
    logic        w_more;
    logic        w_is_reg;
    logic [2:0]  w_vk;

    // A sum smaller than the base PC means the 64-bit address wrapped.
    assign w_addr     = r_pc + {60'd0, r_idx};
    assign w_addr_bad = (w_addr < r_pc) || (w_addr >= 64'(MEM_BYTES));
    assign w_req_ok   = (r_state == S_REQ) && !w_addr_bad;

    assign w_icode   = bus.imem_rdata[7:4];
    assign w_ifun    = bus.imem_rdata[3:0];
    assign w_invalid = (w_icode >= 4'hC) ||
                       ((w_icode == 4'h2 || w_icode == 4'h7) ? (w_ifun > 4'd6) :
                        (w_icode == 4'h6) ? (w_ifun > 4'd3) : (w_ifun != 4'd0));
    // Illegal encodings complete as single-byte instructions.
    assign w_len = w_invalid ? 4'd1 :
                   (w_icode == 4'h7 || w_icode == 4'h8) ? 4'd9 :
                   (w_icode >= 4'h3 && w_icode <= 4'h5) ? 4'd10 :
                   (w_icode == 4'h2 || w_icode == 4'h6 || w_icode == 4'hA || w_icode == 4'hB) ? 4'd2 :
                   4'd1;

    // Length is only known once byte 0 arrives, so use the live decode for idx 0.
    assign w_cur_len = (r_idx == 4'd0) ? w_len : r_len;
    assign w_more    = (r_idx + 4'd1) < w_cur_len;
    // Length 9 has no register byte: bytes 1..8 are valC; length 10 puts valC at bytes 2..9.
    assign w_is_reg  = (r_len != 4'd9) && (r_idx == 4'd1);
    assign w_vk      = 3'((r_len == 4'd10) ? (r_idx - 4'd2) : (r_idx - 4'd1));

    assign bus.pc_ready      = r_pc_ready;
    assign bus.imem_rd       = w_req_ok;
    assign bus.imem_addr     = w_req_ok ? w_addr : 64'd0;
    assign bus.instr_valid   = (r_state == S_DONE);
    assign bus.icode         = r_icode;
    assign bus.ifun          = r_ifun;
    assign bus.ra            = r_ra;
    assign bus.rb            = r_rb;
    assign bus.valc          = r_valc;
    assign bus.valp          = r_valp;
    assign bus.halt          = r_halt;
    assign bus.instr_invalid = r_invalid;
    assign bus.imem_error    = r_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_pc_ready <= 1'b0;
            r_pc       <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_icode    <= '0;
            r_ifun     <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_valc     <= '0;
            r_valp     <= '0;
            r_halt     <= 1'b0;
            r_invalid  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // pc_ready stays low for the first cycle out of reset.
                    if (r_pc_ready && bus.pc_valid) begin
                        r_pc_ready <= 1'b0;
                        r_pc       <= bus.pc_in;
                        r_idx      <= '0;
                        r_len      <= '0;
                        r_icode    <= '0;
                        r_ifun     <= '0;
                        r_ra       <= '0;
                        r_rb       <= '0;
                        r_valc     <= '0;
                        r_valp     <= '0;
                        r_halt     <= 1'b0;
                        r_invalid  <= 1'b0;
                        r_error    <= 1'b0;
                        r_state    <= S_REQ;
                    end else begin
                        r_pc_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_addr_bad) begin
                        r_error <= 1'b1;
                        r_valp  <= r_pc;
                        r_halt  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (r_idx == 4'd0) begin
                            r_icode   <= w_icode;
                            r_ifun    <= w_ifun;
                            r_len     <= w_len;
                            r_invalid <= w_invalid;
                            r_halt    <= (w_icode == 4'h0);
                            r_valp    <= r_pc + {60'd0, w_len};
                            if (w_len == 4'd1 || w_len == 4'd9) begin
                                r_ra <= 4'hF;
                                r_rb <= 4'hF;
                            end
                        end else if (w_is_reg) begin
                            r_ra <= bus.imem_rdata[7:4];
                            r_rb <= bus.imem_rdata[3:0];
                        end else begin
                            r_valc[{w_vk, 3'b000} +: 8] <= bus.imem_rdata;
                        end
                        r_idx   <= w_more ? r_idx + 4'd1 : r_idx;
                        r_state <= w_more ? S_REQ : S_DONE;
                    end
                end
                default: begin
                    if (bus.instr_ready) begin
                        r_pc_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_y86_fetch_sequencer.sv
// tb_y86_fetch_sequencer: directed scenario bench for y86_fetch_sequencer with a byte-memory model
module tb_y86_fetch_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    logic [7:0]  mem [0:1023];
    int          lat;
    int          pend;
    logic [63:0] pend_addr;
    logic [63:0] rd_log [$];
    int          rd_wide;
    int          rd_overlap;
    logic        prev_rd;

    y86_fetch_sequencer_if bus ();

    y86_fetch_sequencer #(.MEM_BYTES(1024)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: answers each read lat cycles later, samples/drives on the falling edge.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 8'h00;
        pend = 0;
        prev_rd = 1'b0;
        rd_wide = 0;
        rd_overlap = 0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = (pend_addr < 64'd1024) ? mem[pend_addr[9:0]] : 8'h00;
                end
            end
            if (bus.imem_rd === 1'b1) begin
                if (prev_rd) rd_wide++;
                if (pend > 0) rd_overlap++;
                pend = lat;
                pend_addr = bus.imem_addr;
                rd_log.push_back(bus.imem_addr);
            end
            prev_rd = (bus.imem_rd === 1'b1);
        end
    end

    // Presents a PC for one cycle, then waits (bounded) for instr_valid; cyc counts cycles from acceptance.
    task automatic run_fetch(input logic [63:0] pc, output int cyc);
        rd_log.delete();
        bus.pc_in = pc;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        cyc = 1;
        while (bus.instr_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bus.pc_valid = 1'b0;
        bus.pc_in = 64'd0;
        bus.instr_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.pc_ready !== 1'b0) $display("FAIL rst_pc_ready got %b want 0", bus.pc_ready); else passes++;
        checks++; if ({bus.imem_rd, bus.instr_valid, bus.halt, bus.instr_invalid, bus.imem_error} !== 5'b0) $display("FAIL rst_flags got %b want 00000", {bus.imem_rd, bus.instr_valid, bus.halt, bus.instr_invalid, bus.imem_error}); else passes++;
        checks++; if ({bus.imem_addr, bus.valc, bus.valp} !== 192'd0) $display("FAIL rst_words got %h %h %h want 0", bus.imem_addr, bus.valc, bus.valp); else passes++;
        checks++; if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h0000) $display("FAIL rst_fields got %h want 0000", {bus.icode, bus.ifun, bus.ra, bus.rb}); else passes++;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.pc_ready !== 1'b0) $display("FAIL rst_release_pc_ready got %b want 0", bus.pc_ready); else passes++;
        @(negedge clk);
        checks++; if (bus.pc_ready !== 1'b1) $display("FAIL rst_after_pc_ready got %b want 1", bus.pc_ready); else passes++;
    endtask

    task automatic test_long;
        int cyc;
        int bad;
        logic [7:0] b [10] = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < 10; i++) mem[i] = b[i];
        run_fetch(64'd0, cyc);
        checks++; if (cyc !== 21) $display("FAIL long_latency got %0d want 21", cyc); else passes++;
        checks++; if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h30F3) $display("FAIL long_fields got %h want 30f3", {bus.icode, bus.ifun, bus.ra, bus.rb}); else passes++;
        checks++; if (bus.valc !== 64'h0102030405060708) $display("FAIL long_valc got %h want 0102030405060708", bus.valc); else passes++;
        checks++; if (bus.valp !== 64'd10) $display("FAIL long_valp got %h want a", bus.valp); else passes++;
        checks++; if ({bus.halt, bus.instr_invalid, bus.imem_error} !== 3'b000) $display("FAIL long_flags got %b want 000", {bus.halt, bus.instr_invalid, bus.imem_error}); else passes++;
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i] !== 64'(i)) bad++;
        checks++; if (rd_log.size() !== 10 || bad !== 0) $display("FAIL long_reads got %0d reads %0d bad want 10 reads 0 bad", rd_log.size(), bad); else passes++;
        consume();
    endtask

    task automatic test_halt;
        int cyc;
        mem[32'h20] = 8'h00;
        run_fetch(64'h20, cyc);
        checks++; if (cyc !== 3) $display("FAIL halt_latency got %0d want 3", cyc); else passes++;
        checks++; if ({bus.halt, bus.instr_invalid, bus.imem_error} !== 3'b100) $display("FAIL halt_flags got %b want 100", {bus.halt, bus.instr_invalid, bus.imem_error}); else passes++;
        checks++; if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h00FF) $display("FAIL halt_fields got %h want 00ff", {bus.icode, bus.ifun, bus.ra, bus.rb}); else passes++;
        checks++; if (bus.valp !== 64'h21 || bus.valc !== 64'd0) $display("FAIL halt_valp_valc got %h %h want 21 0", bus.valp, bus.valc); else passes++;
        checks++; if (rd_log.size() !== 1) $display("FAIL halt_reads got %0d want 1", rd_log.size()); else passes++;
        consume();
    endtask

    task automatic test_invalid;
        int cyc;
        mem[32'h40] = 8'hC0;
        mem[32'h41] = 8'h65;
        run_fetch(64'h40, cyc);
        checks++; if ({bus.instr_invalid, bus.halt, bus.imem_error} !== 3'b100) $display("FAIL inv_c0_flags got %b want 100", {bus.instr_invalid, bus.halt, bus.imem_error}); else passes++;
        checks++; if (bus.valp !== 64'h41 || bus.icode !== 4'hC) $display("FAIL inv_c0_valp got %h icode %h want 41 c", bus.valp, bus.icode); else passes++;
        consume();
        run_fetch(64'h41, cyc);
        checks++; if (bus.instr_invalid !== 1'b1) $display("FAIL inv_65_flag got %b want 1", bus.instr_invalid); else passes++;
        checks++; if (bus.valp !== 64'h42 || {bus.icode, bus.ifun} !== 8'h65) $display("FAIL inv_65_valp got %h code %h want 42 65", bus.valp, {bus.icode, bus.ifun}); else passes++;
        checks++; if (rd_log.size() !== 1 || cyc !== 3) $display("FAIL inv_65_len got %0d reads %0d cyc want 1 3", rd_log.size(), cyc); else passes++;
        consume();
    endtask

    task automatic test_addr_error;
        int cyc;
        mem[1020] = 8'h50;
        mem[1021] = 8'h12;
        mem[1022] = 8'hAA;
        mem[1023] = 8'hBB;
        run_fetch(64'd1020, cyc);
        checks++; if (cyc !== 10) $display("FAIL err_latency got %0d want 10", cyc); else passes++;
        checks++; if ({bus.imem_error, bus.halt, bus.instr_invalid} !== 3'b100) $display("FAIL err_flags got %b want 100", {bus.imem_error, bus.halt, bus.instr_invalid}); else passes++;
        checks++; if (bus.valp !== 64'd1020) $display("FAIL err_valp got %0d want 1020", bus.valp); else passes++;
        checks++; if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h5012 || bus.valc !== 64'hBBAA) $display("FAIL err_fields got %h %h want 5012 bbaa", {bus.icode, bus.ifun, bus.ra, bus.rb}, bus.valc); else passes++;
        checks++; if (rd_log.size() !== 4 || rd_log[rd_log.size() - 1] !== 64'd1023) $display("FAIL err_reads got %0d reads want 4 ending at 1023", rd_log.size()); else passes++;
        consume();
    endtask

    task automatic test_stall;
        int cyc;
        int bad;
        lat = 3;
        rd_wide = 0;
        rd_overlap = 0;
        mem[32'h100] = 8'h80;
        for (int i = 1; i <= 8; i++) mem[32'h100 + i] = 8'(i * 8'h11);
        run_fetch(64'h100, cyc);
        checks++; if (cyc !== 37) $display("FAIL stall_latency got %0d want 37", cyc); else passes++;
        checks++; if (rd_log.size() !== 9 || rd_wide !== 0 || rd_overlap !== 0) $display("FAIL stall_reads got %0d reads %0d wide %0d overlap want 9 0 0", rd_log.size(), rd_wide, rd_overlap); else passes++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.instr_valid !== 1'b1 || bus.pc_ready !== 1'b0 || bus.imem_rd !== 1'b0) bad++;
            if ({bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h80FF || bus.valc !== 64'h8877665544332211 || bus.valp !== 64'h109) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) $display("FAIL stall_hold got %0d unstable cycles want 0", bad); else passes++;
        checks++; if (bus.valc !== 64'h8877665544332211 || bus.valp !== 64'h109) $display("FAIL stall_vals got %h %h want 8877665544332211 109", bus.valc, bus.valp); else passes++;
        consume();
        lat = 1;
    endtask

    task automatic test_reset_wait;
        lat = 3;
        mem[32'h200] = 8'h30;
        bus.pc_in = 64'h200;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.pc_ready, bus.imem_rd, bus.instr_valid, bus.icode, bus.imem_addr} !== 71'd0) $display("FAIL rstw_outputs got %b %b %b %h %h want 0", bus.pc_ready, bus.imem_rd, bus.instr_valid, bus.icode, bus.imem_addr); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.pc_ready !== 1'b1) $display("FAIL rstw_pc_ready got %b want 1", bus.pc_ready); else passes++;
        @(negedge clk);
        #1;
        checks++; if ({bus.icode, bus.ifun, bus.instr_valid, bus.imem_rd, bus.pc_ready} !== 11'b1) $display("FAIL rstw_no_capture got %h %h %b %b %b want 0 0 0 0 1", bus.icode, bus.ifun, bus.instr_valid, bus.imem_rd, bus.pc_ready); else passes++;
        lat = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        mem[32'h60] = 8'h20;
        mem[32'h61] = 8'h12;
        mem[32'h62] = 8'h61;
        mem[32'h63] = 8'h34;
        run_fetch(64'h60, cyc);
        checks++; if (cyc !== 5 || {bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h2012 || bus.valp !== 64'h62) $display("FAIL b2b_first got %0d %h %h want 5 2012 62", cyc, {bus.icode, bus.ifun, bus.ra, bus.rb}, bus.valp); else passes++;
        consume();
        checks++; if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) $display("FAIL b2b_idle got valid %b ready %b want 0 1", bus.instr_valid, bus.pc_ready); else passes++;
        run_fetch(64'h62, cyc);
        checks++; if (cyc !== 5 || {bus.icode, bus.ifun, bus.ra, bus.rb} !== 16'h6134 || bus.valp !== 64'h64) $display("FAIL b2b_second got %0d %h %h want 5 6134 64", cyc, {bus.icode, bus.ifun, bus.ra, bus.rb}, bus.valp); else passes++;
        consume();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        lat = 1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_long();
        test_halt();
        test_invalid();
        test_addr_error();
        test_stall();
        test_reset_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
